// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Data-memory model that answers two kinds of request:
//   * word access   : combinational read, byte-lane write in the IDLE state
//   * block access  : 8-word (256-bit) read/write with a handshake latency
//
// Storage is 2^ADDR_BITS 32-bit words. A word is addressed by
// address[ADDR_BITS+1:2]. An 8-word block is addressed by
// address[ADDR_BITS+1:5]. Higher address bits are ignored, so addresses
// wrap modulo the memory size.
//
// Ports
//   CLK                    clock
//   RESET                  asynchronous active-high reset
//   data_address_2DM[31:0] byte address, shared by word and block access
//   MemRead_2DM            word read request
//   MemWrite_2DM           word write request
//   data_write_2DM[31:0]   word write data
//   data_write_size_2DM    number of bytes to write (1,2,3; 0 means 4)
//   data_read_fDM[31:0]    word read data (0 when MemRead_2DM is low)
//   dBlkRead / dBlkWrite   level-held block requests
//   block_write_2DM[255:0] block write data, word i at bits[255-32i -: 32]
//   block_read_fDM[255:0]  registered block read data
//   block_read_fDM_valid   block read done
//   block_write_fDM_valid  block write done
//
// Optional feature: define DMEM_RAND_LATENCY_EN to draw each block latency
// from a 16-bit LFSR (1 .. LATENCY). Left undefined, every block request
// takes exactly LATENCY cycles.
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 4
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [31:0]  data_address_2DM,
    input  logic         MemRead_2DM,
    input  logic         MemWrite_2DM,
    input  logic [31:0]  data_write_2DM,
    input  logic [1:0]   data_write_size_2DM,
    output logic [31:0]  data_read_fDM,
    input  logic         dBlkRead,
    input  logic         dBlkWrite,
    input  logic [255:0] block_write_2DM,
    output logic [255:0] block_read_fDM,
    output logic         block_read_fDM_valid,
    output logic         block_write_fDM_valid
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam int BASE_BITS = ADDR_BITS - 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    logic [31:0] mem [DEPTH];

    // Address decode
    logic [ADDR_BITS-1:0] word_idx;
    logic [BASE_BITS-1:0] blk_base;
    logic                 addr_unused;

    assign word_idx    = data_address_2DM[ADDR_BITS+1:2];
    assign blk_base    = data_address_2DM[ADDR_BITS+1:5];
    assign addr_unused = ^data_address_2DM[31:ADDR_BITS+2];

    // State
    state_t               state_q,  state_d;
    logic [3:0]           cnt_q,    cnt_d;
    logic                 op_wr_q,  op_wr_d;
    logic [BASE_BITS-1:0] base_q,   base_d;
    logic [255:0]         rdata_q,  rdata_d;
    logic                 rvalid_q, rvalid_d;
    logic                 wvalid_q, wvalid_d;

    logic [4:0]           lat;
    logic                 req_held;
    logic                 blk_commit;
    logic                 word_we;
    logic [31:0]          word_merged;
    logic [255:0]         blk_rdata;

`ifdef DMEM_RAND_LATENCY_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        lfsr_fb;

    // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign lat     = 5'(({28'd0, lfsr_q[3:0]} % 32'(LATENCY)) + 32'd1);
`else
    assign lat     = 5'(LATENCY);
`endif

    // ------------------------------------------------------------------
    // Word access
    // ------------------------------------------------------------------
    assign data_read_fDM = MemRead_2DM ? mem[word_idx] : 32'd0;
    assign word_we       = MemWrite_2DM && (state_q == ST_IDLE);

    // Big-endian byte lanes: lane k (byte offset k) lives at bits[31-8k -: 8].
    // The n bytes written are the low n bytes of the data word, most
    // significant first, placed at offset..offset+n-1; anything that would
    // land past lane 3 is simply dropped.
    always_comb begin
        int n;
        int off;
        word_merged = mem[word_idx];
        n   = (data_write_size_2DM == 2'd0) ? 4 : int'(data_write_size_2DM);
        off = int'(data_address_2DM[1:0]);
        for (int k = 0; k < 4; k++) begin
            if ((k >= off) && ((k - off) < n)) begin
                word_merged[31-8*k -: 8] = data_write_2DM[8*(n-1-(k-off)) +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Block access
    // ------------------------------------------------------------------
    // Gather the 8 words of the latched block for a read completion.
    for (genvar gi = 0; gi < 8; gi++) begin : g_blk_rd
        assign blk_rdata[255-32*gi -: 32] = mem[{base_q, 3'(gi)}];
    end

    assign req_held   = op_wr_q ? dBlkWrite : dBlkRead;
    assign blk_commit = (state_q == ST_WAIT) && (cnt_q == 4'd0) && req_held && op_wr_q;

    // Storage is deliberately outside the reset domain: reset never alters it.
    // Block commit and word write cannot coincide (WAIT vs IDLE).
    always_ff @(posedge CLK) begin
        if (blk_commit) begin
            for (int i = 0; i < 8; i++) begin
                mem[{base_q, 3'(i)}] <= block_write_2DM[255-32*i -: 32];
            end
        end else if (word_we) begin
            mem[word_idx] <= word_merged;
        end
    end

    // ------------------------------------------------------------------
    // Block FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        base_d  = base_q;
        rdata_d = rdata_q;
`ifdef DMEM_RAND_LATENCY_EN
        lfsr_d  = lfsr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (dBlkWrite || dBlkRead) begin
                    state_d = ST_WAIT;
                    // Counter expires after lat edges including this one
                    cnt_d   = 4'(lat - 5'd1);
                    op_wr_d = dBlkWrite;   // write wins when both are raised
                    base_d  = blk_base;
`ifdef DMEM_RAND_LATENCY_EN
                    lfsr_d  = {lfsr_q[14:0], lfsr_fb};
`endif
                end
            end
            ST_WAIT: begin
                if (!req_held) begin
                    state_d = ST_IDLE;     // abort: no commit, no valid
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_ACK;
                    if (!op_wr_q) begin
                        rdata_d = blk_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACK: begin
                if (!req_held) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        wvalid_d = (state_d == ST_ACK) &&  op_wr_d;
        rvalid_d = (state_d == ST_ACK) && !op_wr_d;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            op_wr_q  <= 1'b0;
            base_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            wvalid_q <= 1'b0;
`ifdef DMEM_RAND_LATENCY_EN
            lfsr_q   <= 16'hACE1;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_wr_q  <= op_wr_d;
            base_q   <= base_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            wvalid_q <= wvalid_d;
`ifdef DMEM_RAND_LATENCY_EN
            lfsr_q   <= lfsr_d;
`endif
        end
    end

    assign block_read_fDM        = rdata_q;
    assign block_read_fDM_valid  = rvalid_q;
    assign block_write_fDM_valid = wvalid_q;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed bench for dmem_responder (ADDR_BITS=10, LATENCY=4). Inputs change
// 1 time unit after the rising edge; outputs are sampled shortly after that,
// well away from the next edge. With DMEM_RAND_LATENCY_EN defined the bench
// instead measures 20 random latencies, resets, and repeats the measurement.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  addr;
    logic         mem_rd;
    logic         mem_wr;
    logic [31:0]  wdata;
    logic [1:0]   wsize;
    logic [31:0]  rdata;
    logic         blk_rd;
    logic         blk_wr;
    logic [255:0] blk_wdata;
    logic [255:0] blk_rdata;
    logic         rvalid;
    logic         wvalid;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_BITS(10), .LATENCY(LAT)) dut (
        .CLK                   (clk),
        .RESET                 (rst),
        .data_address_2DM      (addr),
        .MemRead_2DM           (mem_rd),
        .MemWrite_2DM          (mem_wr),
        .data_write_2DM        (wdata),
        .data_write_size_2DM   (wsize),
        .data_read_fDM         (rdata),
        .dBlkRead              (blk_rd),
        .dBlkWrite             (blk_wr),
        .block_write_2DM       (blk_wdata),
        .block_read_fDM        (blk_rdata),
        .block_read_fDM_valid  (rvalid),
        .block_write_fDM_valid (wvalid)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic word_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        addr   = a;
        wdata  = d;
        wsize  = sz;
        mem_wr = 1'b1;
        tick;
        mem_wr = 1'b0;
    endtask

    task automatic word_read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr   = a;
        mem_rd = 1'b1;
        #1;
        check(tag, 256'(rdata), 256'(exp));
        mem_rd = 1'b0;
        #1;
    endtask

    // Full block transaction at fixed latency: valid stays low for the
    // acceptance edge and LAT-1 following edges, rises after edge t+LAT,
    // then falls one edge after the request is dropped.
    task automatic run_block(input string tag, input bit is_wr, input logic [31:0] a,
                             input logic [255:0] wd, input logic [255:0] exp_rd);
        addr      = a;
        blk_wdata = wd;
        if (is_wr) blk_wr = 1'b1; else blk_rd = 1'b1;
        for (int k = 0; k < LAT; k++) begin
            tick;
            check({tag, "_wait_valid"}, 256'(is_wr ? wvalid : rvalid), 256'(0));
        end
        tick;
        check({tag, "_valid"}, 256'(is_wr ? wvalid : rvalid), 256'(1));
        check({tag, "_other_valid"}, 256'(is_wr ? rvalid : wvalid), 256'(0));
        if (!is_wr) check({tag, "_data"}, blk_rdata, exp_rd);
        blk_wr = 1'b0;
        blk_rd = 1'b0;
        tick;
        check({tag, "_drop_valid"}, 256'(is_wr ? wvalid : rvalid), 256'(0));
    endtask

`ifdef DMEM_RAND_LATENCY_EN
    task automatic measure(output int lat);
        lat    = 0;
        addr   = 32'h60;
        blk_rd = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick;
            if (rvalid) begin
                lat = k - 1;
                break;
            end
        end
        blk_rd = 1'b0;
        tick;
    endtask
`endif

    logic [255:0] pat, pat2, pat3;
    int lats1 [20];
    int lats2 [20];

    initial begin
        rst       = 1'b1;
        addr      = 32'd0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        wdata     = 32'd0;
        wsize     = 2'd0;
        blk_rd    = 1'b0;
        blk_wr    = 1'b0;
        blk_wdata = '0;
        for (int i = 0; i < 8; i++) begin
            pat[255-32*i -: 32]  = 32'hC0DE0000 | 32'(i);
            pat3[255-32*i -: 32] = 32'h5A000000 + 32'(i) * 32'h00010203;
        end
        pat2 = ~pat;

        tick;
        tick;
        check("rst_rvalid", 256'(rvalid), 256'(0));
        check("rst_wvalid", 256'(wvalid), 256'(0));
        check("rst_blk_rdata", blk_rdata, 256'(0));
        check("rst_word_rd_idle", 256'(rdata), 256'(0));
        rst = 1'b0;
        tick;

`ifdef DMEM_RAND_LATENCY_EN
        for (int i = 0; i < 20; i++) begin
            measure(lats1[i]);
            check("lat_range", 256'((lats1[i] >= 1) && (lats1[i] <= LAT)), 256'(1));
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tick;
        for (int i = 0; i < 20; i++) begin
            measure(lats2[i]);
            check("lat_repeat", 256'(lats2[i]), 256'(lats1[i]));
        end
`else
        // Word access
        word_write(32'h40, 32'hDEADBEEF, 2'd0);
        word_read_check("word_full", 32'h40, 32'hDEADBEEF);
        check("word_rd_low", 256'(rdata), 256'(0));
        word_write(32'h40, 32'h11223344, 2'd0);
        word_write(32'h41, 32'h000000AA, 2'd1);
        word_read_check("word_sz1", 32'h40, 32'h11AA3344);
        word_write(32'h42, 32'h00CCDDEE, 2'd3);
        word_read_check("word_sz3_clip", 32'h40, 32'h11AACCDD);
        word_write(32'h40, 32'h00005566, 2'd2);
        word_read_check("word_sz2", 32'h40, 32'h5566CCDD);
        word_read_check("word_wrap", 32'h1040, 32'h5566CCDD);

        // Block write then read of the same block via an unaligned address
        run_block("bwr", 1'b1, 32'h60, pat, '0);
        run_block("brd", 1'b0, 32'h7F, '0, pat);
        check("brd_hold", blk_rdata, pat);
        word_read_check("blk_word0", 32'h60, pat[255:224]);
        word_read_check("blk_word1", 32'h64, pat[223:192]);

        // Read aborted after 2 WAIT cycles, then an immediate full read
        addr   = 32'h60;
        blk_rd = 1'b1;
        tick;
        tick;
        tick;
        blk_rd = 1'b0;
        tick;
        check("abort_rd_valid", 256'(rvalid), 256'(0));
        run_block("after_abort_rd", 1'b0, 32'h60, '0, pat);

        // Write aborted mid-WAIT must not commit
        addr      = 32'h60;
        blk_wdata = pat2;
        blk_wr    = 1'b1;
        tick;
        tick;
        tick;
        blk_wr = 1'b0;
        tick;
        check("abort_wr_valid", 256'(wvalid), 256'(0));
        run_block("after_abort_wr", 1'b0, 32'h60, '0, pat);

        // Reset while in ACK clears valid and read data at once
        addr   = 32'h60;
        blk_rd = 1'b1;
        for (int k = 0; k <= LAT; k++) tick;
        check("ack_rvalid", 256'(rvalid), 256'(1));
        rst = 1'b1;
        #1;
        check("rst_ack_rvalid", 256'(rvalid), 256'(0));
        check("rst_ack_rdata", blk_rdata, 256'(0));
        blk_rd = 1'b0;
        tick;
        rst = 1'b0;

        // Reset mid-WAIT of a block write must not commit
        addr      = 32'h60;
        blk_wdata = pat2;
        blk_wr    = 1'b1;
        tick;
        tick;
        rst = 1'b1;
        #1;
        check("rst_wait_wvalid", 256'(wvalid), 256'(0));
        blk_wr = 1'b0;
        tick;
        rst = 1'b0;
        run_block("after_rst_wait", 1'b0, 32'h60, '0, pat);

        // Both requests at once: write wins; word write in WAIT ignored
        word_write(32'h100, 32'hCAFEF00D, 2'd0);
        addr      = 32'h80;
        blk_wdata = pat3;
        blk_wr    = 1'b1;
        blk_rd    = 1'b1;
        tick;
        addr   = 32'h100;
        wdata  = 32'h12345678;
        wsize  = 2'd0;
        mem_wr = 1'b1;
        tick;
        mem_wr = 1'b0;
        addr   = 32'h80;
        tick;
        tick;
        check("both_wait_wvalid", 256'(wvalid), 256'(0));
        tick;
        check("both_wvalid", 256'(wvalid), 256'(1));
        check("both_rvalid", 256'(rvalid), 256'(0));
        blk_wr = 1'b0;
        blk_rd = 1'b0;
        tick;
        check("both_drop_wvalid", 256'(wvalid), 256'(0));
        word_read_check("wait_word_wr_ignored", 32'h100, 32'hCAFEF00D);
        run_block("both_readback", 1'b0, 32'h80, '0, pat3);
        word_read_check("both_word1", 32'h84, pat3[223:192]);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
